// File: rtl/piso_serial_tx_pkg.sv
// Shared types and defaults for the PISO serial transmitter.
// Shared with the matching SIPO receiver.
package piso_serial_tx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } st_e;

  localparam int DEF_W  = 8;
  localparam int DEF_CW = 3;

endpackage

// File: rtl/piso_serial_tx_if.sv
// Load handshake and serial link bundle for the PISO transmitter.
// master: data source / sink side; slave: the transmitter.
// d,ld: word + load request; rdy: idle; so,sv: serial bit + valid; done: frame end.
interface piso_serial_tx_if #(
  parameter int W = 8
) ();

  logic [W-1:0] d;
  logic         ld;
  logic         rdy;
  logic         so;
  logic         sv;
  logic         done;

  modport master (
    output d, ld,
    input  rdy, so, sv, done
  );

  modport slave (
    input  d, ld,
    output rdy, so, sv, done
  );

endinterface

// File: rtl/piso_serial_tx_shift_stage.sv
// One bit of the shift register: load/shift mux into an async-clear flop.
// clk,rst_n: clock/reset; load,shift: mux selects; d_i,s_i: sources; q_o: bit.
module piso_serial_tx_shift_stage (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic shift,
  input  logic d_i,
  input  logic s_i,
  output logic q_o
);

  logic bit_q;
  logic bit_d;

  always_comb begin
    bit_d = bit_q;
    if (load) begin
      bit_d = d_i;
    end else if (shift) begin
      bit_d = s_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q <= 1'b0;
    end else begin
      bit_q <= bit_d;
    end
  end

  assign q_o = bit_q;

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter, MSB first, with frame valid and done.
// c: clock; re_: async active-low reset; bus: slave side of piso_serial_tx_if.
module piso_serial_tx
  import piso_serial_tx_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int CW = DEF_CW
) (
  input  logic            c,
  input  logic            re_,
  piso_serial_tx_if.slave bus
);

  localparam logic [CW-1:0] LAST = CW'(W - 1);

  st_e           st_q;
  st_e           st_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          done_q;
  logic          done_d;

  logic [W-1:0]  sr;
  logic          load;
  logic          shift;

  assign load  = (st_q == ST_IDLE) & bus.ld;
  assign shift = (st_q == ST_SHIFT);

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    unique case (1'b1)
      load: begin
        st_d  = ST_SHIFT;
        cnt_d = '0;
      end
      shift: begin
        if (cnt_q == LAST) begin
          // hold cnt so it never wraps
          st_d   = ST_IDLE;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge c or negedge re_) begin
    if (!re_) begin
      st_q   <= ST_IDLE;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  for (genvar i = 0; i < W; i++) begin : g_stage
    logic s_in;
    if (i == 0) begin : g_lsb
      assign s_in = 1'b0;
    end else begin : g_mid
      assign s_in = sr[i-1];
    end
    piso_serial_tx_shift_stage u_stage (
      .clk   (c),
      .rst_n (re_),
      .load  (load),
      .shift (shift),
      .d_i   (bus.d[i]),
      .s_i   (s_in),
      .q_o   (sr[i])
    );
  end

  assign bus.rdy  = ~shift;
  assign bus.sv   = shift;
  assign bus.so   = sr[W-1] & shift;
  assign bus.done = done_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Directed bench for piso_serial_tx (W=8 and W=4 builds).
module tb_piso_serial_tx;

  logic c;
  logic re_;
  logic clk_en;

  int n_chk;
  int n_fail;

  piso_serial_tx_if #(.W(8)) bus ();
  piso_serial_tx_if #(.W(4)) bus4 ();

  piso_serial_tx #(.W(8), .CW(3)) dut (
    .c   (c),
    .re_ (re_),
    .bus (bus)
  );

  piso_serial_tx #(.W(4), .CW(2)) dut4 (
    .c   (c),
    .re_ (re_),
    .bus (bus4)
  );

  initial begin
    c = 1'b0;
    forever #5 c = clk_en ? ~c : 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      nm;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  // Entered 1ns after the load edge; leaves 1ns after the done edge.
  task automatic run_bits(input string nm, input logic [7:0] exp);
    for (int i = 7; i >= 0; i--) begin
      chk({nm, " so"}, 32'(bus.so), 32'(exp[i]));
      chk({nm, " sv"}, 32'(bus.sv), 32'd1);
      chk({nm, " rdy"}, 32'(bus.rdy), 32'd0);
      chk({nm, " done"}, 32'(bus.done), 32'd0);
      tick();
    end
    chk({nm, " end sv"}, 32'(bus.sv), 32'd0);
    chk({nm, " end so"}, 32'(bus.so), 32'd0);
    chk({nm, " end done"}, 32'(bus.done), 32'd1);
    chk({nm, " end rdy"}, 32'(bus.rdy), 32'd1);
  endtask

  task automatic load_one(input logic [7:0] d);
    bus.d  = d;
    bus.ld = 1'b1;
    tick();
    bus.ld = 1'b0;
  endtask

  initial begin
    logic [3:0] exp4;
    n_chk   = 0;
    n_fail  = 0;
    clk_en  = 1'b0;
    re_     = 1'b0;
    bus.d   = '0;
    bus.ld  = 1'b0;
    bus4.d  = '0;
    bus4.ld = 1'b0;

    tbl[0] = '{"vA5", 8'hA5, 8'b1010_0101};
    tbl[1] = '{"v00", 8'h00, 8'b0000_0000};
    tbl[2] = '{"vFF", 8'hFF, 8'b1111_1111};
    tbl[3] = '{"v0F", 8'h0F, 8'b0000_1111};
    tbl[4] = '{"v81", 8'h81, 8'b1000_0001};
    tbl[5] = '{"v3C", 8'h3C, 8'b0011_1100};

    // reset with no clock running
    #3;
    chk("rst rdy", 32'(bus.rdy), 32'd1);
    chk("rst so", 32'(bus.so), 32'd0);
    chk("rst sv", 32'(bus.sv), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst4 rdy", 32'(bus4.rdy), 32'd1);
    re_ = 1'b1;
    #2;
    clk_en = 1'b1;
    repeat (3) tick();
    chk("idle rdy", 32'(bus.rdy), 32'd1);
    chk("idle sv", 32'(bus.sv), 32'd0);
    chk("idle done", 32'(bus.done), 32'd0);

    // table of single frames
    for (int v = 0; v < 6; v++) begin
      load_one(tbl[v].d);
      run_bits(tbl[v].nm, tbl[v].exp);
      tick();
      chk({tbl[v].nm, " done clr"}, 32'(bus.done), 32'd0);
      chk({tbl[v].nm, " idle sv"}, 32'(bus.sv), 32'd0);
    end

    // ld held during shift: ignored until the idle cycle
    bus.d  = 8'hA5;
    bus.ld = 1'b1;
    tick();
    bus.d = 8'hFF;
    run_bits("hold A5", 8'b1010_0101);
    tick();
    bus.ld = 1'b0;
    run_bits("hold FF", 8'b1111_1111);
    tick();

    // back-to-back, one sv=0 gap
    bus.d  = 8'h81;
    bus.ld = 1'b1;
    tick();
    bus.d = 8'h7E;
    run_bits("b2b 81", 8'b1000_0001);
    tick();
    bus.ld = 1'b0;
    run_bits("b2b 7E", 8'b0111_1110);
    tick();

    // reset after the third bit of C3
    load_one(8'hC3);
    chk("abort b7", 32'(bus.so), 32'd1);
    tick();
    chk("abort b6", 32'(bus.so), 32'd1);
    tick();
    chk("abort b5", 32'(bus.so), 32'd0);
    #2;
    re_ = 1'b0;
    #1;
    chk("abort so", 32'(bus.so), 32'd0);
    chk("abort sv", 32'(bus.sv), 32'd0);
    chk("abort rdy", 32'(bus.rdy), 32'd1);
    chk("abort done", 32'(bus.done), 32'd0);
    tick();
    chk("abort done2", 32'(bus.done), 32'd0);
    re_ = 1'b1;
    tick();
    chk("post rst done", 32'(bus.done), 32'd0);
    load_one(8'h0F);
    run_bits("post rst 0F", 8'b0000_1111);
    tick();

    // W=4 build
    exp4     = 4'b1001;
    bus4.d   = 4'h9;
    bus4.ld  = 1'b1;
    tick();
    bus4.ld = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      chk("w4 so", 32'(bus4.so), 32'(exp4[i]));
      chk("w4 sv", 32'(bus4.sv), 32'd1);
      chk("w4 done", 32'(bus4.done), 32'd0);
      tick();
    end
    chk("w4 end done", 32'(bus4.done), 32'd1);
    chk("w4 end sv", 32'(bus4.sv), 32'd0);
    chk("w4 end rdy", 32'(bus4.rdy), 32'd1);
    tick();
    chk("w4 done clr", 32'(bus4.done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
